// File: rtl/btb_predictor_pkg.sv
// ============================================================================
// Module  : btb_pkg
// Brief   : Counter encodings and BTB entry layout shared by the predictor.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package btb_pkg;

  localparam logic [1:0] CTR_SNT   = 2'b00;
  localparam logic [1:0] CTR_WNT   = 2'b01;
  localparam logic [1:0] CTR_WT    = 2'b10;
  localparam logic [1:0] CTR_ST    = 2'b11;
  localparam logic [1:0] CTR_RST   = CTR_WNT;
  localparam logic [1:0] CTR_ALLOC = CTR_WT;

  // Tag is held zero-extended to the widest possible tag (PC[31:2]).
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    logic [31:0] target;
    logic [1:0]  ctr;
  } btb_entry_t;

endpackage

`default_nettype wire

// File: rtl/btb_predictor_if.sv
// ============================================================================
// Module  : btb_predictor_if
// Brief   : Fetch lookup, EX update and redirect signals of the BTB.
//           BTB_STATS_EN adds the branch/mispredict counters.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

interface btb_predictor_if;
  logic [31:0] PCF;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic        UpdateE;
  logic [31:0] PCE;
  logic        BrTakenE;
  logic [31:0] BrTargetE;
  logic        PredTakenE;
  logic [31:0] PredTargetE;
  logic        MispredE;
  logic [31:0] CorrectPCE;
`ifdef BTB_STATS_EN
  logic [31:0] BranchCntO;
  logic [31:0] MispredCntO;

  modport master (
    output PCF, UpdateE, PCE, BrTakenE, BrTargetE, PredTakenE, PredTargetE,
    input  PredTakenF, PredTargetF, MispredE, CorrectPCE, BranchCntO, MispredCntO
  );
  modport slave (
    input  PCF, UpdateE, PCE, BrTakenE, BrTargetE, PredTakenE, PredTargetE,
    output PredTakenF, PredTargetF, MispredE, CorrectPCE, BranchCntO, MispredCntO
  );
`else
  modport master (
    output PCF, UpdateE, PCE, BrTakenE, BrTargetE, PredTakenE, PredTargetE,
    input  PredTakenF, PredTargetF, MispredE, CorrectPCE
  );
  modport slave (
    input  PCF, UpdateE, PCE, BrTakenE, BrTargetE, PredTakenE, PredTargetE,
    output PredTakenF, PredTargetF, MispredE, CorrectPCE
  );
`endif
endinterface

`default_nettype wire

// File: rtl/btb_predictor_ctr2.sv
// ============================================================================
// Module  : btb_ctr2
// Brief   : Next-state function of a 2-bit saturating direction counter.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module btb_ctr2
  import btb_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != CTR_ST) ctr_o = ctr_i + 2'd1;
    end else begin
      if (ctr_i != CTR_SNT) ctr_o = ctr_i - 2'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/btb_predictor.sv
// ============================================================================
// Module  : btb_predictor
// Brief   : Direct-mapped BTB with 2-bit counters; IF lookup, EX update and
//           redirect. Optional counters enabled by BTB_STATS_EN.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module btb_predictor
  import btb_pkg::*;
#(
  parameter int ENTRIES = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  btb_predictor_if.slave  bus
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  btb_entry_t table_q [ENTRIES];

  logic [IDX_W-1:0] f_idx, e_idx;
  logic [TAG_W-1:0] f_tag, e_tag;
  btb_entry_t       f_ent, e_ent, e_ent_d;
  logic             f_hit, e_hit, pred_taken, wr_en, mispred;
  logic [1:0]       ctr_nxt;

  assign f_idx = bus.PCF[IDX_W+1:2];
  assign f_tag = bus.PCF[31:IDX_W+2];
  assign e_idx = bus.PCE[IDX_W+1:2];
  assign e_tag = bus.PCE[31:IDX_W+2];

  // Lookup reads the registered table, so a same-cycle update is not visible.
  assign f_ent      = table_q[f_idx];
  assign f_hit      = f_ent.valid && (f_ent.tag == {{IDX_W{1'b0}}, f_tag});
  assign pred_taken = f_hit && (f_ent.ctr >= CTR_WT);

  assign bus.PredTakenF  = pred_taken;
  assign bus.PredTargetF = pred_taken ? f_ent.target : bus.PCF + 32'd4;

  assign e_ent = table_q[e_idx];
  assign e_hit = e_ent.valid && (e_ent.tag == {{IDX_W{1'b0}}, e_tag});

  btb_ctr2 u_ctr2 (
    .ctr_i   (e_ent.ctr),
    .taken_i (bus.BrTakenE),
    .ctr_o   (ctr_nxt)
  );

  always_comb begin
    e_ent_d = e_ent;
    wr_en   = 1'b0;
    if (bus.UpdateE) begin
      if (e_hit) begin
        wr_en       = 1'b1;
        e_ent_d.ctr = ctr_nxt;
        if (bus.BrTakenE) e_ent_d.target = bus.BrTargetE;
      end else if (bus.BrTakenE) begin
        wr_en          = 1'b1;
        e_ent_d.valid  = 1'b1;
        e_ent_d.tag    = {{IDX_W{1'b0}}, e_tag};
        e_ent_d.target = bus.BrTargetE;
        e_ent_d.ctr    = CTR_ALLOC;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i].valid <= 1'b0;
        table_q[i].ctr   <= CTR_RST;
      end
    end else if (wr_en) begin
      table_q[e_idx] <= e_ent_d;
    end
  end

  assign mispred = bus.UpdateE &&
                   ((bus.PredTakenE != bus.BrTakenE) ||
                    (bus.BrTakenE && bus.PredTakenE && (bus.PredTargetE != bus.BrTargetE)));

  assign bus.MispredE   = mispred;
  assign bus.CorrectPCE = bus.BrTakenE ? bus.BrTargetE : bus.PCE + 32'd4;

`ifdef BTB_STATS_EN
  logic [31:0] branch_cnt_q, mispred_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      branch_cnt_q  <= 32'd0;
      mispred_cnt_q <= 32'd0;
    end else begin
      if (bus.UpdateE) branch_cnt_q  <= branch_cnt_q + 32'd1;
      if (mispred)     mispred_cnt_q <= mispred_cnt_q + 32'd1;
    end
  end

  assign bus.BranchCntO  = branch_cnt_q;
  assign bus.MispredCntO = mispred_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_btb_predictor.sv
// ============================================================================
// Module  : tb_btb_predictor
// Brief   : Directed bench for btb_predictor with a reference table model.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_btb_predictor;

  localparam int ENTRIES = 64;
  localparam int IDX_W   = $clog2(ENTRIES);

  logic clk;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  btb_predictor_if bus ();

  btb_predictor #(.ENTRIES(ENTRIES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (act=timeout req=finish)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // Reference table: one slot per index holding the full tag and an integer counter.
  bit          mv  [ENTRIES];
  logic [31:0] mt  [ENTRIES];
  logic [31:0] mtg [ENTRIES];
  int          mc  [ENTRIES];
  logic [31:0] mbr, mmis;
  bit          started = 0;

  function automatic int midx(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic logic [31:0] mtagof(input logic [31:0] pc);
    return pc >> (IDX_W + 2);
  endfunction

  int          ci;
  bit          chit, ctk, emis;
  logic [31:0] ctg;

  always @(negedge clk) begin
    if (started) begin
      ci   = midx(bus.PCF);
      chit = mv[ci] && (mt[ci] == mtagof(bus.PCF));
      ctk  = chit && (mc[ci] >= 2);
      ctg  = ctk ? mtg[ci] : bus.PCF + 32'd4;
      emis = bus.UpdateE && ((bus.PredTakenE != bus.BrTakenE) ||
             (bus.BrTakenE && (bus.PredTargetE != bus.BrTargetE)));
      chk("PredTakenF", {31'd0, bus.PredTakenF}, {31'd0, ctk});
      chk("PredTargetF", bus.PredTargetF, ctg);
      chk("MispredE", {31'd0, bus.MispredE}, {31'd0, emis});
      chk("CorrectPCE", bus.CorrectPCE, bus.BrTakenE ? bus.BrTargetE : bus.PCE + 32'd4);
`ifdef BTB_STATS_EN
      chk("BranchCntO", bus.BranchCntO, mbr);
      chk("MispredCntO", bus.MispredCntO, mmis);
`endif
    end
    // Apply the effect of the coming rising edge to the model.
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mv[i] = 1'b0;
        mc[i] = 1;
      end
      mbr     = 32'd0;
      mmis    = 32'd0;
      started = 1;
    end else if (started && bus.UpdateE) begin
      emis = (bus.PredTakenE != bus.BrTakenE) ||
             (bus.BrTakenE && (bus.PredTargetE != bus.BrTargetE));
      mbr  = mbr + 32'd1;
      if (emis) mmis = mmis + 32'd1;
      ci   = midx(bus.PCE);
      chit = mv[ci] && (mt[ci] == mtagof(bus.PCE));
      if (chit) begin
        if (bus.BrTakenE) begin
          mc[ci]  = (mc[ci] == 3) ? 3 : mc[ci] + 1;
          mtg[ci] = bus.BrTargetE;
        end else begin
          mc[ci]  = (mc[ci] == 0) ? 0 : mc[ci] - 1;
        end
      end else if (bus.BrTakenE) begin
        mv[ci]  = 1'b1;
        mt[ci]  = mtagof(bus.PCE);
        mtg[ci] = bus.BrTargetE;
        mc[ci]  = 2;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.UpdateE     = 1'b0;
    bus.PCE         = 32'd0;
    bus.BrTakenE    = 1'b0;
    bus.BrTargetE   = 32'd0;
    bus.PredTakenE  = 1'b0;
    bus.PredTargetE = 32'd0;
  endtask

  task automatic upd(input logic [31:0] pce, input logic tk, input logic [31:0] tgt,
                     input logic ptk, input logic [31:0] ptg);
    bus.UpdateE     = 1'b1;
    bus.PCE         = pce;
    bus.BrTakenE    = tk;
    bus.BrTargetE   = tgt;
    bus.PredTakenE  = ptk;
    bus.PredTargetE = ptg;
  endtask

  task automatic expect_f(input string name, input logic tk, input logic [31:0] tgt);
    #1;
    chk({name, "_taken"}, {31'd0, bus.PredTakenF}, {31'd0, tk});
    chk({name, "_target"}, bus.PredTargetF, tgt);
  endtask

  task automatic expect_e(input string name, input logic mis, input logic [31:0] cpc);
    #1;
    chk({name, "_mispred"}, {31'd0, bus.MispredE}, {31'd0, mis});
    chk({name, "_cpc"}, bus.CorrectPCE, cpc);
  endtask

  logic [31:0] pcs [5];

  initial begin
    rst_n   = 1'b0;
    bus.PCF = 32'h100;
    idle();
    repeat (3) cyc();
    rst_n = 1'b1;

    // Reset state
    expect_f("reset", 1'b0, 32'h104);
    expect_e("reset", 1'b0, 32'h4);

    // Allocate and predict
    upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    expect_e("alloc", 1'b1, 32'h80);
    cyc(); idle();
    expect_f("alloc_pred", 1'b1, 32'h80);

    // Hysteresis, including saturation at 3
    upd(32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    expect_e("hyst_nt", 1'b1, 32'h104);
    cyc(); idle();
    expect_f("hyst_01", 1'b0, 32'h104);
    upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h104); cyc();
    upd(32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
    expect_e("hyst_ok", 1'b0, 32'h80);
    cyc();
    upd(32'h100, 1'b1, 32'h80, 1'b1, 32'h80); cyc();
    upd(32'h100, 1'b0, 32'h80, 1'b1, 32'h80); cyc(); idle();
    expect_f("hyst_10", 1'b1, 32'h80);

    // Aliasing on index 0
    bus.PCF = 32'h200;
    expect_f("alias_miss", 1'b0, 32'h204);
    upd(32'h200, 1'b1, 32'h300, 1'b0, 32'h204); cyc(); idle();
    expect_f("alias_new", 1'b1, 32'h300);
    bus.PCF = 32'h100;
    expect_f("alias_old", 1'b0, 32'h104);

    // Same-index read and write
    upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h104); cyc();
    upd(32'h100, 1'b1, 32'h40, 1'b1, 32'h80);
    expect_f("rbw_old", 1'b1, 32'h80);
    expect_e("rbw", 1'b1, 32'h40);
    cyc(); idle();
    expect_f("rbw_new", 1'b1, 32'h40);

    // Target mismatch, then a correct prediction
    upd(32'h100, 1'b1, 32'h90, 1'b1, 32'h80);
    expect_e("tgt_mis", 1'b1, 32'h90);
    cyc();
    upd(32'h100, 1'b1, 32'h90, 1'b1, 32'h90);
    expect_e("tgt_ok", 1'b0, 32'h90);
    cyc();

    // MispredE must stay low without UpdateE
    upd(32'h100, 1'b1, 32'h90, 1'b0, 32'h0);
    bus.UpdateE = 1'b0;
    expect_e("no_upd", 1'b0, 32'h90);
    idle();

    // Fall-through wraps mod 2^32
    bus.PCF = 32'hFFFF_FFFC;
    expect_f("wrap", 1'b0, 32'h0);

    // Reset mid-operation discards the concurrent update and invalidates all
    bus.PCF = 32'h100;
    upd(32'h100, 1'b1, 32'h500, 1'b1, 32'h90);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1; idle();
    expect_f("midrst", 1'b0, 32'h104);

    // Mixed traffic checked by the model every cycle
    pcs[0] = 32'h100; pcs[1] = 32'h200; pcs[2] = 32'h104;
    pcs[3] = 32'h300; pcs[4] = 32'hFFFF_FFFC;
    for (int k = 0; k < 200; k++) begin
      bus.PCF = pcs[$urandom_range(0, 4)];
      if ($urandom_range(0, 3) != 0)
        upd(pcs[$urandom_range(0, 4)], 1'($urandom_range(0, 1)),
            {24'd0, 6'($urandom_range(0, 63)), 2'b00},
            1'($urandom_range(0, 1)), {24'd0, 6'($urandom_range(0, 63)), 2'b00});
      else
        idle();
      cyc();
    end
    idle();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
